xdma_usr_irq_ctrl: RTL and testbench

Host-facing control end of the XDMA user-interrupt path. AXI4-Lite slave on the XDMA AXI-Lite master (BAR) port. The host uses it to:
- read pending interrupt status;
- write-1-to-clear interrupts, producing the `intr_clr`/`intr_clr_vld` pulses consumed by the interrupt request generator;
- read per-source interrupt counters and the XDMA `usr_irq_ack` status.

---
 rtl/xdma_usr_irq_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_xdma_usr_irq_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xdma_usr_irq_ctrl.sv
// xdma_usr_irq_ctrl: AXI4-Lite register block on the XDMA BAR port giving the host
// interrupt status, write-1-to-clear pulses, usr_irq_ack status and per-source edge counters.
// Ports: clk/sys_rst (async, active-high); s_axil_* AXI4-Lite slave (12-bit address, 32-bit data);
//        xdma_usr_irq_req/usr_irq_ack in from the request generator / XDMA IP;
//        intr_clr/intr_clr_vld out, a one-cycle clear pulse per written CLEAR bit.
module xdma_usr_irq_ctrl #(
  parameter int          INTR_COUNT = 7,
  parameter logic [31:0] VERSION    = 32'h0001_0000
) (
  input  logic                  clk,
  input  logic                  sys_rst,
  input  logic [11:0]           s_axil_awaddr,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [31:0]           s_axil_wdata,
  input  logic [3:0]            s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [11:0]           s_axil_araddr,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [31:0]           s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  input  logic [INTR_COUNT-1:0] xdma_usr_irq_req,
  input  logic [INTR_COUNT-1:0] usr_irq_ack,
  output logic [INTR_COUNT-1:0] intr_clr,
  output logic [INTR_COUNT-1:0] intr_clr_vld
);

  // Word offsets (byte address >> 2)
  localparam logic [9:0] A_STATUS  = 10'h000;
  localparam logic [9:0] A_CLEAR   = 10'h001;
  localparam logic [9:0] A_ACK     = 10'h002;
  localparam logic [9:0] A_CNT_CLR = 10'h004;
  localparam logic [9:0] A_VERSION = 10'h007;
  localparam logic [9:0] A_CNT0    = 10'h010;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // Responses are always OKAY
  assign s_axil_bresp = 2'b00;
  assign s_axil_rresp = 2'b00;

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  w_state_t    w_state, w_state_nx;
  logic        aw_done, aw_done_nx;
  logic        w_done, w_done_nx;
  logic [11:0] wr_addr, wr_addr_nx;
  logic [31:0] wr_data, wr_data_nx;
  logic        awready_nx, wready_nx, bvalid_nx;
  logic        wr_fire;
  logic [11:0] act_addr;
  logic [31:0] act_data;
  logic        aw_hs, w_hs;

  assign aw_hs = s_axil_awvalid & s_axil_awready;
  assign w_hs  = s_axil_wvalid & s_axil_wready;

  // The register action may fire on the same edge as the last handshake, so
  // take address/data from the bus when that channel is completing right now.
  assign act_addr = aw_done ? wr_addr : s_axil_awaddr;
  assign act_data = w_done ? wr_data : s_axil_wdata;

  always_comb begin
    w_state_nx = w_state;
    aw_done_nx = aw_done;
    w_done_nx  = w_done;
    wr_addr_nx = wr_addr;
    wr_data_nx = wr_data;
    awready_nx = 1'b0;
    wready_nx  = 1'b0;
    bvalid_nx  = 1'b0;
    wr_fire    = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (aw_hs) begin
          aw_done_nx = 1'b1;
          wr_addr_nx = s_axil_awaddr;
        end
        if (w_hs) begin
          w_done_nx  = 1'b1;
          wr_data_nx = s_axil_wdata;
        end
        if (aw_done_nx && w_done_nx) begin
          wr_fire    = 1'b1;
          w_state_nx = W_RESP;
          bvalid_nx  = 1'b1;
        end else begin
          awready_nx = ~aw_done_nx;
          wready_nx  = ~w_done_nx;
        end
      end
      W_RESP: begin
        if (s_axil_bready) begin
          w_state_nx = W_IDLE;
          aw_done_nx = 1'b0;
          w_done_nx  = 1'b0;
          awready_nx = 1'b1;
          wready_nx  = 1'b1;
        end else begin
          bvalid_nx = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      w_state        <= W_IDLE;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      s_axil_awready <= 1'b0;
      s_axil_wready  <= 1'b0;
      s_axil_bvalid  <= 1'b0;
    end else begin
      w_state        <= w_state_nx;
      aw_done        <= aw_done_nx;
      w_done         <= w_done_nx;
      wr_addr        <= wr_addr_nx;
      wr_data        <= wr_data_nx;
      s_axil_awready <= awready_nx;
      s_axil_wready  <= wready_nx;
      s_axil_bvalid  <= bvalid_nx;
    end
  end

  logic clear_fire, cnt_clr_fire;
  assign clear_fire   = wr_fire && (act_addr[11:2] == A_CLEAR);
  assign cnt_clr_fire = wr_fire && (act_addr[11:2] == A_CNT_CLR);

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      intr_clr     <= '0;
      intr_clr_vld <= '0;
    end else if (clear_fire) begin
      intr_clr     <= act_data[INTR_COUNT-1:0];
      intr_clr_vld <= act_data[INTR_COUNT-1:0];
    end else begin
      intr_clr     <= '0;
      intr_clr_vld <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // ACK status and edge counters
  // ---------------------------------------------------------------------------
  logic [INTR_COUNT-1:0]       ack_q;
  logic [INTR_COUNT-1:0]       req_d;
  logic [INTR_COUNT-1:0]       rise;
  logic [INTR_COUNT-1:0][31:0] cnt_all;

  assign rise = xdma_usr_irq_req & ~req_d;

  // Sticky while the request stays high; drops the cycle after req is low.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      ack_q <= '0;
      req_d <= '0;
    end else begin
      ack_q <= (ack_q | usr_irq_ack) & xdma_usr_irq_req;
      req_d <= xdma_usr_irq_req;
    end
  end

  for (genvar g = 0; g < INTR_COUNT; g++) begin : g_cnt
    logic [31:0] cnt;
    // A clear coinciding with an edge counts that edge.
    always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst)
        cnt <= '0;
      else if (cnt_clr_fire)
        cnt <= rise[g] ? 32'd1 : 32'd0;
      else if (rise[g] && (cnt != 32'hFFFF_FFFF))
        cnt <= cnt + 32'd1;
      else
        cnt <= cnt;
    end
    assign cnt_all[g] = cnt;
  end

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  r_state_t    r_state, r_state_nx;
  logic        arready_nx, rvalid_nx;
  logic [31:0] rdata_nx;
  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    case (s_axil_araddr[11:2])
      A_STATUS:  rd_mux[INTR_COUNT-1:0] = xdma_usr_irq_req;
      A_ACK:     rd_mux[INTR_COUNT-1:0] = ack_q;
      A_VERSION: rd_mux = VERSION;
      default: begin
        for (int i = 0; i < INTR_COUNT; i++)
          if (s_axil_araddr[11:2] == A_CNT0 + 10'(i))
            rd_mux = cnt_all[i];
      end
    endcase
  end

  always_comb begin
    r_state_nx = r_state;
    arready_nx = 1'b0;
    rvalid_nx  = 1'b0;
    rdata_nx   = s_axil_rdata;
    case (r_state)
      R_IDLE: begin
        if (s_axil_arvalid && s_axil_arready) begin
          r_state_nx = R_DATA;
          rvalid_nx  = 1'b1;
          rdata_nx   = rd_mux;
        end else begin
          arready_nx = 1'b1;
        end
      end
      R_DATA: begin
        if (s_axil_rready) begin
          r_state_nx = R_IDLE;
          arready_nx = 1'b1;
        end else begin
          rvalid_nx = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state        <= R_IDLE;
      s_axil_arready <= 1'b0;
      s_axil_rvalid  <= 1'b0;
      s_axil_rdata   <= '0;
    end else begin
      r_state        <= r_state_nx;
      s_axil_arready <= arready_nx;
      s_axil_rvalid  <= rvalid_nx;
      s_axil_rdata   <= rdata_nx;
    end
  end

  // Byte lanes, sub-word address bits and upper data bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{s_axil_wstrb, s_axil_araddr[1:0], act_addr[1:0], act_data};

endmodule

// File: tb/tb_xdma_usr_irq_ctrl.sv
// Testbench for xdma_usr_irq_ctrl: directed scenarios plus randomized traffic,
// with expected read data, write responses and clear pulses queued from a
// behavioural register model and checked by an independent monitor.
module tb_xdma_usr_irq_ctrl;
  localparam int N = 7;

  logic          clk = 1'b0;
  logic          sys_rst = 1'b0;
  logic [11:0]   awaddr = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = 4'hF;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b1;
  logic [11:0]   araddr = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  ack = '0;
  logic [N-1:0]  clr;
  logic [N-1:0]  clr_vld;

  always #5 clk = ~clk;

  xdma_usr_irq_ctrl #(.INTR_COUNT(N), .VERSION(32'h0001_0000)) dut (
    .clk(clk), .sys_rst(sys_rst),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .xdma_usr_irq_req(req), .usr_irq_ack(ack),
    .intr_clr(clr), .intr_clr_vld(clr_vld)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [N-1:0] m_ack = '0;
  logic [N-1:0] m_prev = '0;
  logic [31:0]  m_cnt [N];
  logic         aw_got = 1'b0, w_got = 1'b0;
  logic [11:0]  cap_addr = '0;
  logic [31:0]  cap_data = '0;

  // Scoreboard queues
  logic [31:0]  rd_q [$];
  logic [N-1:0] clr_q [$];
  logic [1:0]   b_q [$];
  int           b_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a);
    int w;
    w = int'(a[11:2]);
    if (w == 0) return 32'(req);
    if (w == 2) return 32'(m_ack);
    if (w == 7) return 32'h0001_0000;
    if (w >= 16 && w < 16 + N) return m_cnt[w-16];
    return 32'h0;
  endfunction

  // One clock: predict what the DUT does at the coming edge, then advance.
  task automatic step();
    logic         aw_hs, w_hs, ar_hs, fire;
    logic [N-1:0] rise;
    aw_hs = awvalid && awready;
    w_hs  = wvalid && wready;
    ar_hs = arvalid && arready;
    if (ar_hs) rd_q.push_back(model_read(araddr));
    if (aw_hs) begin aw_got = 1'b1; cap_addr = awaddr; end
    if (w_hs)  begin w_got = 1'b1; cap_data = wdata; end
    fire = aw_got && w_got;
    rise = req & ~m_prev;
    for (int i = 0; i < N; i++) begin
      if (fire && cap_addr[11:2] == 10'h004)
        m_cnt[i] = rise[i] ? 32'd1 : 32'd0;
      else if (rise[i] && m_cnt[i] != 32'hFFFF_FFFF)
        m_cnt[i] = m_cnt[i] + 32'd1;
      if (ack[i] && req[i]) m_ack[i] = 1'b1;
      else if (!req[i])     m_ack[i] = 1'b0;
    end
    m_prev = req;
    if (fire) begin
      b_q.push_back(2'b00);
      if (cap_addr[11:2] == 10'h001 && cap_data[N-1:0] != '0)
        clr_q.push_back(cap_data[N-1:0]);
      aw_got = 1'b0;
      w_got  = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    if (aw_hs) awvalid = 1'b0;
    if (w_hs)  wvalid  = 1'b0;
    if (ar_hs) arvalid = 1'b0;
  endtask

  function automatic logic busy();
    return awvalid || wvalid || arvalid || aw_got || w_got || bvalid || rvalid ||
           (rd_q.size() != 0) || (b_q.size() != 0);
  endfunction

  task automatic settle();
    int n = 0;
    while (busy() && n < 60) begin step(); n++; end
    if (busy()) begin
      checks++; errors++;
      $display("FAIL settle_timeout: bus still busy after %0d cycles", n);
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    settle();
  endtask

  task automatic rd(input logic [11:0] a);
    araddr = a; arvalid = 1'b1;
    settle();
  endtask

  task automatic reset_model();
    m_ack = '0; m_prev = '0; aw_got = 1'b0; w_got = 1'b0;
    for (int i = 0; i < N; i++) m_cnt[i] = '0;
    rd_q.delete(); clr_q.delete(); b_q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_handshake"}, 32'({awready, wready, bvalid, arready, rvalid}), 32'h0);
    chk({tag, "_rdata"}, rdata, 32'h0);
    chk({tag, "_clr"}, 32'({clr, clr_vld}), 32'h0);
    chk({tag, "_resp"}, 32'({bresp, rresp}), 32'h0);
  endtask

  // Monitor: compares DUT responses against the queued expectations.
  initial begin : monitor
    logic [31:0] held;
    logic        hold_vld;
    hold_vld = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      #2;
      if (sys_rst) begin
        hold_vld = 1'b0;
      end else begin
        if (clr_vld != '0) begin
          if (clr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL clr_unexpected: got %h expected no pulse", clr_vld);
          end else begin
            logic [N-1:0] e;
            e = clr_q.pop_front();
            chk("clr_vld", 32'(clr_vld), 32'(e));
            chk("clr_mask", 32'(clr), 32'(e));
          end
        end else if (clr != '0) begin
          chk("clr_without_vld", 32'(clr), 32'h0);
        end
        if (hold_vld && rvalid) chk("rdata_stable", rdata, held);
        if (rvalid && rready) begin
          hold_vld = 1'b0;
          if (rd_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_unexpected: got %h expected no read data", rdata);
          end else begin
            chk("rdata", rdata, rd_q.pop_front());
            chk("rresp", 32'(rresp), 32'h0);
          end
        end else if (rvalid) begin
          held = rdata;
          hold_vld = 1'b1;
        end else begin
          hold_vld = 1'b0;
        end
        if (bvalid && bready) begin
          b_seen++;
          if (b_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected: got bresp %h expected no response", bresp);
          end else begin
            chk("bresp", 32'(bresp), 32'(b_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int b0, idx;
    logic aw_pend, w_pend;
    for (int i = 0; i < N; i++) m_cnt[i] = '0;

    // Power-on reset
    #1 sys_rst = 1'b1;
    #6;
    chk_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    sys_rst = 1'b0;
    step();
    chk("ready_after_reset", 32'({awready, wready, arready}), 32'h7);

    // Reset in the middle of a write (AW taken, W pending)
    rd(12'h01C);
    awaddr = 12'h004; wdata = 32'h5; awvalid = 1'b1;
    step();
    chk("aw_taken", 32'(aw_got), 32'h1);
    sys_rst = 1'b1;
    #1;
    chk_reset_outputs("midwr");
    awvalid = 1'b0; wvalid = 1'b0;
    reset_model();
    @(negedge clk);
    sys_rst = 1'b0;
    step();
    chk("ready_after_rst2", 32'({awready, wready, arready}), 32'h7);
    wr(12'h004, 32'h5);

    // CLEAR with W leading AW, bready late by 3 cycles
    req = 7'h7F;
    step(); step();
    bready = 1'b0;
    wdata = 32'h41; wvalid = 1'b1; awaddr = 12'h004;
    step();
    awvalid = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      chk("bvalid_hold", 32'(bvalid), 32'h1);
      step();
    end
    bready = 1'b1;
    settle();

    // STATUS / ACK
    req = '0; step(); step();
    req = 7'h04; step();
    ack = 7'h04; step();
    ack = '0;
    rd(12'h000);
    rd(12'h008);
    req = '0; step();
    rd(12'h008);

    // Counters: 5 edges, then CNT_CLR together with a 6th edge
    for (int k = 0; k < 5; k++) begin
      req[6] = 1'b1; step();
      req[6] = 1'b0; step();
    end
    rd(12'h058);
    awaddr = 12'h010; wdata = 32'h0; awvalid = 1'b1; wvalid = 1'b1; req[6] = 1'b1;
    step();
    req[6] = 1'b0;
    settle();
    rd(12'h058);

    // Read held under backpressure while a write proceeds
    b0 = b_seen;
    rready = 1'b0;
    araddr = 12'h01C; arvalid = 1'b1;
    awaddr = 12'h004; wdata = 32'h12; awvalid = 1'b1; wvalid = 1'b1;
    step();
    for (int k = 0; k < 4; k++) step();
    chk("write_during_read", 32'(b_seen - b0), 32'h1);
    rready = 1'b1;
    settle();
    rd(12'h100);

    // Saturation of CNT[0]
    req = '0; step();
    force dut.g_cnt[0].cnt = 32'hFFFF_FFFE;
    m_cnt[0] = 32'hFFFF_FFFE;
    step();
    release dut.g_cnt[0].cnt;
    for (int k = 0; k < 3; k++) begin
      req[0] = 1'b1; step();
      req[0] = 1'b0; step();
    end
    rd(12'h040);

    // Randomized traffic
    aw_pend = 1'b0; w_pend = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        idx = $urandom_range(0, N-1);
        req[idx] = ~req[idx];
      end
      ack    = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      bready = ($urandom_range(0, 3) != 0);
      rready = ($urandom_range(0, 3) != 0);
      wstrb  = 4'($urandom);
      if (!arvalid && $urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 5))
          0: araddr = 12'h000;
          1: araddr = 12'h008;
          2: araddr = 12'h01C;
          3: araddr = 12'($urandom_range(0, 1023) * 4);
          default: araddr = 12'h040 + 12'($urandom_range(0, N) * 4);
        endcase
        araddr[1:0] = 2'($urandom);
        arvalid = 1'b1;
      end
      if (!awvalid && !wvalid && !aw_pend && !w_pend && $urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 7))
          0: awaddr = 12'h010;
          1: awaddr = 12'($urandom_range(0, 1023) * 4);
          default: awaddr = 12'h004;
        endcase
        awaddr[1:0] = 2'($urandom);
        wdata = $urandom;
        aw_pend = 1'b1; w_pend = 1'b1;
      end
      if (aw_pend && $urandom_range(0, 1) == 0) begin awvalid = 1'b1; aw_pend = 1'b0; end
      if (w_pend && $urandom_range(0, 1) == 0)  begin wvalid = 1'b1; w_pend = 1'b0; end
      step();
    end
    ack = '0; bready = 1'b1; rready = 1'b1;
    if (aw_pend) awvalid = 1'b1;
    if (w_pend) wvalid = 1'b1;
    settle();
    // Final sweep of every counter and status register against the model
    for (int i = 0; i < N; i++) rd(12'h040 + 12'(i * 4));
    rd(12'h000);
    rd(12'h008);
    step(); step();
    chk("rd_queue_drained", rd_q.size(), 32'h0);
    chk("clr_queue_drained", clr_q.size(), 32'h0);
    chk("b_queue_drained", b_q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
